gshare_branch_predictor: RTL

- Global-history (gshare) conditional branch predictor behind the branch controller.
- Receives a predict request when a conditional branch is decoded and returns a TAKEN/NOT_TAKEN prediction in the same cycle.
- Trains a table of 2-bit saturating counters when the branch resolves in EX.
- Keeps a speculative global history register (GHR) and an in-order FIFO of history snapshots, so a mispredict can restore the history precisely.

---
 rtl/gshare_branch_predictor.sv | 123 ++++++++++++
 1 files changed

// File: rtl/gshare_branch_predictor.sv
// Gshare conditional branch predictor: same-cycle prediction from a 2-bit counter table
// indexed by PC xor speculative global history, trained at resolve, with history snapshot FIFO.
module gshare_branch_predictor #(
  parameter int INDEX_BITS = 8,
  parameter int GHR_BITS   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dec_valid,
  input  logic        dec_stall,
  input  logic [31:0] dec_pc,
  output logic        pred_taken,
  input  logic        ex_valid,
  input  logic        ex_stall,
  input  logic [31:0] ex_pc,
  input  logic        ex_outcome,
  output logic        mispredict,
  output logic        hist_overflow,
  output logic        hist_underflow
);

  localparam int ENTRIES   = 1 << INDEX_BITS;
  localparam int PTR_BITS  = $clog2(FIFO_DEPTH) + 1;
  localparam int ADDR_BITS = PTR_BITS - 1;

  logic [1:0]            ctr [ENTRIES];
  logic [GHR_BITS-1:0]   ghr;
  logic [GHR_BITS-1:0]   snap_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] pred_mem;
  logic [PTR_BITS-1:0]   wr_ptr;
  logic [PTR_BITS-1:0]   rd_ptr;

  logic                  dec_acc;
  logic                  ex_acc;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  pop;
  logic                  push;
  logic                  mis_now;
  logic [GHR_BITS-1:0]   head_snap;
  logic                  head_pred;
  logic [INDEX_BITS-1:0] ghr_ext;
  logic [INDEX_BITS-1:0] snap_ext;
  logic [INDEX_BITS-1:0] pred_idx;
  logic [INDEX_BITS-1:0] train_idx;
  logic [1:0]            train_old;
  logic [1:0]            train_new;
  logic                  unused_pc_bits;

  assign unused_pc_bits = ^{dec_pc[31:INDEX_BITS+2], dec_pc[1:0],
                            ex_pc[31:INDEX_BITS+2], ex_pc[1:0]};

  assign dec_acc    = dec_valid & ~dec_stall;
  assign ex_acc     = ex_valid & ~ex_stall;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_BITS-1] != rd_ptr[PTR_BITS-1]) &&
                      (wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]);

  assign head_snap = snap_mem[rd_ptr[ADDR_BITS-1:0]];
  assign head_pred = pred_mem[rd_ptr[ADDR_BITS-1:0]];

  always_comb begin
    ghr_ext  = '0;
    snap_ext = '0;
    ghr_ext[GHR_BITS-1:0]  = ghr;
    snap_ext[GHR_BITS-1:0] = head_snap;
  end

  assign pred_idx   = dec_pc[INDEX_BITS+1:2] ^ ghr_ext;
  assign train_idx  = ex_pc[INDEX_BITS+1:2] ^ snap_ext;
  assign pred_taken = ctr[pred_idx][1];

  assign pop     = ex_acc & ~fifo_empty;
  assign mis_now = pop & (head_pred != ex_outcome);
  // A same-cycle pop frees the slot; a mispredict squashes the younger predict entirely.
  assign push    = dec_acc & ~mis_now & (~fifo_full | pop);

  always_comb begin
    train_old = ctr[train_idx];
    train_new = train_old;
    if (ex_outcome) begin
      if (train_old != 2'd3) train_new = train_old + 2'd1;
    end else begin
      if (train_old != 2'd0) train_new = train_old - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
      ghr            <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      mispredict     <= 1'b0;
      hist_overflow  <= 1'b0;
      hist_underflow <= 1'b0;
    end else begin
      mispredict <= mis_now;
      if (pop) ctr[train_idx] <= train_new;
      if (dec_acc && fifo_full && !pop) hist_overflow <= 1'b1;
      if (ex_acc && fifo_empty) hist_underflow <= 1'b1;

      if (mis_now) begin
        ghr    <= {head_snap[GHR_BITS-2:0], ex_outcome};
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (dec_acc) ghr <= {ghr[GHR_BITS-2:0], pred_taken};
        if (push) wr_ptr <= wr_ptr + PTR_BITS'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      snap_mem[wr_ptr[ADDR_BITS-1:0]] <= ghr;
      pred_mem[wr_ptr[ADDR_BITS-1:0]] <= pred_taken;
    end
  end

endmodule
